// File: rtl/aska_stim_seq_pkg.sv
// Shared definitions for the stimulation sequencer: conf field layout,
// electrode count and FSM state encoding.
package aska_stim_seq_pkg;

  localparam int ELEC_NUM = 31;

  localparam int PERIOD_LSB = 0;
  localparam int PERIOD_W   = 12;
  localparam int AMP_LSB    = 12;
  localparam int AMP_W      = 6;
  localparam int RAMP_LSB   = 18;
  localparam int RAMP_W     = 6;
  localparam int ON_LSB     = 24;
  localparam int ON_W       = 8;

  localparam int RF_LSB     = 0;
  localparam int RF_W       = 10;
  localparam int OFF_LSB    = 10;
  localparam int OFF_W      = 10;
  localparam int EN_BIT     = 20;
  localparam int PHASE_LSB  = 21;
  localparam int PHASE_W    = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PH1,
    S_GAP,
    S_PH2,
    S_REST,
    S_OFF
  } state_t;

  function automatic logic [15:0] max16(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/aska_stim_seq_ramp_gen.sv
// Per-pulse amplitude: linear ramp k*ramp_factor (Q6.4) saturated at the
// programmed amplitude, latched when a pulse starts.
module aska_stim_seq_ramp_gen
  import aska_stim_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset_l,
  input  logic              load,
  input  logic [ON_W-1:0]   k,
  input  logic [AMP_W-1:0]  amplitude,
  input  logic [RAMP_W-1:0] ramp,
  input  logic [RF_W-1:0]   ramp_factor,
  output logic [AMP_W-1:0]  amp_next,
  output logic [AMP_W-1:0]  amp_k
);

  logic [15:0] prod;
  logic [15:0] scaled;

  // k never exceeds ramp (<=63) on the ramp branch, so the product fits in 16 bits
  assign prod   = 16'(k) * 16'(ramp_factor);
  assign scaled = prod >> 4;

  always_comb begin
    amp_next = amplitude;
    if ((ramp != '0) && (16'(k) <= 16'(ramp)) && (scaled < 16'(amplitude))) begin
      amp_next = scaled[AMP_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      amp_k <= '0;
    end else if (load) begin
      amp_k <= amp_next;
    end
  end

endmodule

// File: rtl/aska_stim_seq.sv
// Stimulation sequencer: turns the latched conf/electrode settings into biphasic,
// charge-balanced current pulse trains with ON/OFF bursts and an amplitude ramp.
module aska_stim_seq
  import aska_stim_seq_pkg::*;
#(
  parameter int ELEC_W = ELEC_NUM + 1,
  parameter int IPG    = 1
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic [31:0]       conf0,
  input  logic [31:0]       conf1,
  input  logic [ELEC_W-1:0] ele1,
  input  logic [ELEC_W-1:0] ele2,
  output logic [ELEC_W-1:0] up_switches,
  output logic [ELEC_W-1:0] down_switches,
  output logic [AMP_W-1:0]  DAC,
  output logic              pulse_active,
  output logic              burst_on
);

  localparam logic [15:0] IPG_T = 16'(IPG);

  state_t             state_q, state_d;
  logic [15:0]        t_q, t_d;
  logic [ON_W-1:0]    k_q, k_d;
  logic [OFF_W-1:0]   off_cnt_q, off_cnt_d;
  logic               load, pulse_start;

  logic [PERIOD_W-1:0] period_in, period_s;
  logic [AMP_W-1:0]    amp_in, amp_s, cur_amp;
  logic [RAMP_W-1:0]   ramp_in, ramp_s, cur_ramp;
  logic [ON_W-1:0]     on_in, on_s;
  logic [RF_W-1:0]     rf_in, rf_s, cur_rf;
  logic [OFF_W-1:0]    off_in, off_s;
  logic [PHASE_W-1:0]  phase_in, phase_s;
  logic [ELEC_W-1:0]   ele1_s, ele2_s, cur_ele1, cur_ele2;
  logic                en_in, start_ok, cur_valid;
  logic [15:0]         ph, per;
  logic [AMP_W-1:0]    amp_next, amp_k;
  logic                unused_conf1;

  assign period_in    = conf0[PERIOD_LSB +: PERIOD_W];
  assign amp_in       = conf0[AMP_LSB +: AMP_W];
  assign ramp_in      = conf0[RAMP_LSB +: RAMP_W];
  assign on_in        = conf0[ON_LSB +: ON_W];
  assign rf_in        = conf1[RF_LSB +: RF_W];
  assign off_in       = conf1[OFF_LSB +: OFF_W];
  assign en_in        = conf1[EN_BIT];
  assign phase_in     = conf1[PHASE_LSB +: PHASE_W];
  assign unused_conf1 = ^conf1[31:PHASE_LSB+PHASE_W];

  assign start_ok = en_in && (on_in != '0);

  // On a burst start the live config is used directly, the shadow copy only from the next tick
  assign cur_amp   = load ? amp_in  : amp_s;
  assign cur_ramp  = load ? ramp_in : ramp_s;
  assign cur_rf    = load ? rf_in   : rf_s;
  assign cur_ele1  = load ? ele1    : ele1_s;
  assign cur_ele2  = load ? ele2    : ele2_s;
  assign cur_valid = (cur_ele1 != '0) && (cur_ele2 != '0) && ((cur_ele1 & cur_ele2) == '0);

  assign ph  = (phase_s == '0) ? 16'd1 : 16'(phase_s);
  assign per = max16(16'(period_s), (ph << 1) + IPG_T + 16'd1);

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      period_s <= '0;
      amp_s    <= '0;
      ramp_s   <= '0;
      on_s     <= '0;
      rf_s     <= '0;
      off_s    <= '0;
      phase_s  <= '0;
      ele1_s   <= '0;
      ele2_s   <= '0;
    end else if (load) begin
      period_s <= period_in;
      amp_s    <= amp_in;
      ramp_s   <= ramp_in;
      on_s     <= on_in;
      rf_s     <= rf_in;
      off_s    <= off_in;
      phase_s  <= phase_in;
      ele1_s   <= ele1;
      ele2_s   <= ele2;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q   <= S_IDLE;
      t_q       <= '0;
      k_q       <= '0;
      off_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      k_q       <= k_d;
      off_cnt_q <= off_cnt_d;
    end
  end

  // t counts ticks since PH1 start (or since the start of the current OFF period)
  always_comb begin
    state_d   = state_q;
    t_d       = t_q + 16'd1;
    k_d       = k_q;
    off_cnt_d = off_cnt_q;
    load      = 1'b0;
    case (state_q)
      S_IDLE: begin
        t_d = '0;
        if (start_ok) begin
          state_d = S_PH1;
          k_d     = ON_W'(1);
          load    = 1'b1;
        end
      end
      S_PH1: if (t_q == ph - 16'd1) state_d = S_GAP;
      S_GAP: if (t_q == ph + IPG_T - 16'd1) state_d = S_PH2;
      S_PH2: if (t_q == (ph << 1) + IPG_T - 16'd1) state_d = S_REST;
      S_REST: begin
        if (t_q == per - 16'd1) begin
          t_d = '0;
          if (!en_in) begin
            state_d = S_IDLE;
            k_d     = '0;
          end else if (k_q != on_s) begin
            state_d = S_PH1;
            k_d     = k_q + ON_W'(1);
          end else if (off_s != '0) begin
            state_d   = S_OFF;
            off_cnt_d = '0;
          end else if (start_ok) begin
            state_d = S_PH1;
            k_d     = ON_W'(1);
            load    = 1'b1;
          end else begin
            state_d = S_IDLE;
            k_d     = '0;
          end
        end
      end
      S_OFF: begin
        if (!en_in) begin
          state_d = S_IDLE;
          t_d     = '0;
          k_d     = '0;
        end else if (t_q == per - 16'd1) begin
          t_d = '0;
          if (off_cnt_q != off_s - OFF_W'(1)) begin
            off_cnt_d = off_cnt_q + OFF_W'(1);
          end else if (start_ok) begin
            state_d = S_PH1;
            k_d     = ON_W'(1);
            load    = 1'b1;
          end else begin
            state_d = S_IDLE;
            k_d     = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pulse_start = (state_d == S_PH1) && (state_q != S_PH1);

  aska_stim_seq_ramp_gen u_ramp_gen (
    .clk         (clk),
    .reset_l     (reset_l),
    .load        (pulse_start),
    .k           (k_d),
    .amplitude   (cur_amp),
    .ramp        (cur_ramp),
    .ramp_factor (cur_rf),
    .amp_next    (amp_next),
    .amp_k       (amp_k)
  );

  // Outputs follow the state being entered, so they line up with it on the same edge
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      up_switches   <= '0;
      down_switches <= '0;
      DAC           <= '0;
      pulse_active  <= 1'b0;
      burst_on      <= 1'b0;
    end else begin
      up_switches   <= '0;
      down_switches <= '0;
      DAC           <= '0;
      pulse_active  <= 1'b0;
      burst_on      <= (state_d == S_PH1) || (state_d == S_GAP) ||
                       (state_d == S_PH2) || (state_d == S_REST);
      case (state_d)
        S_PH1: begin
          if (cur_valid) begin
            up_switches   <= cur_ele1;
            down_switches <= cur_ele2;
            DAC           <= amp_next;
            pulse_active  <= 1'b1;
          end
        end
        S_GAP: pulse_active <= cur_valid;
        S_PH2: begin
          if (cur_valid) begin
            up_switches   <= cur_ele2;
            down_switches <= cur_ele1;
            DAC           <= amp_k;
            pulse_active  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
